// File: rtl/tone_synth.sv
// tone_synth: polyphonic square-wave tone generator with shared octave band.
// Optional: define TONE_SYNTH_BAND_WRAP_EN for modulo-8 band stepping.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   keys[NUM_KEYS]   level key switches; lowest set bits claim voices
//   pause            rising edge toggles en
//   left / right     rising edge steps band down / up
//   adj, bandi[3]    while adj is high, band loads bandi (clamped)
//   en, band         playback enable, current octave band
//   wave, active     per-voice square wave and voice-assigned flag
//   mix, bell        count / OR of sounding voices, 0 while en=0
module tone_synth #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int NUM_KEYS = 16,
    parameter int VOICES   = 2,
    parameter int BAND_MAX = 7,
    localparam int MIX_W   = $clog2(VOICES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                pause,
    input  logic                left,
    input  logic                right,
    input  logic                adj,
    input  logic [2:0]          bandi,
    output logic                en,
    output logic [2:0]          band,
    output logic [VOICES-1:0]   wave,
    output logic [VOICES-1:0]   active,
    output logic [MIX_W-1:0]    mix,
    output logic                bell
);

    localparam logic [2:0] BAND_TOP = 3'(BAND_MAX);

    // Half-period for key k at band b; divisions fold to constants.
    function automatic logic [31:0] hp_of(input logic [3:0] k,
                                          input logic [2:0] b);
        logic [31:0] base;
        logic [31:0] hp;
        case (k)
            4'd0:  base = 32'(CLK_HZ / (2 * 1865));
            4'd1:  base = 32'(CLK_HZ / (2 * 1976));
            4'd2:  base = 32'(CLK_HZ / (2 * 2093));
            4'd3:  base = 32'(CLK_HZ / (2 * 2217));
            4'd4:  base = 32'(CLK_HZ / (2 * 2349));
            4'd5:  base = 32'(CLK_HZ / (2 * 2489));
            4'd6:  base = 32'(CLK_HZ / (2 * 2637));
            4'd7:  base = 32'(CLK_HZ / (2 * 2794));
            4'd8:  base = 32'(CLK_HZ / (2 * 2960));
            4'd9:  base = 32'(CLK_HZ / (2 * 3136));
            4'd10: base = 32'(CLK_HZ / (2 * 3322));
            4'd11: base = 32'(CLK_HZ / (2 * 3520));
            4'd12: base = 32'(CLK_HZ / (2 * 3729));
            4'd13: base = 32'(CLK_HZ / (2 * 3951));
            4'd14: base = 32'(CLK_HZ / (2 * 4186));
            default: base = 32'(CLK_HZ / (2 * 4434));
        endcase
        hp = base << b;
        if (hp < 32'd2) begin
            hp = 32'd2;
        end
        return hp;
    endfunction

    logic              en_q, en_d;
    logic [2:0]        band_q, band_d;
    logic              pause_q, pause_d;
    logic              left_q, left_d;
    logic              right_q, right_d;
    logic [31:0]       cnt_q [VOICES];
    logic [31:0]       cnt_d [VOICES];
    logic [31:0]       hp_q [VOICES];
    logic [31:0]       hp_d [VOICES];
    logic [3:0]        key_q [VOICES];
    logic [3:0]        key_d [VOICES];
    logic [VOICES-1:0] active_q, active_d;
    logic [VOICES-1:0] wave_q, wave_d;

    logic [3:0]        sel_key [VOICES];
    logic [VOICES-1:0] sel_act;
    logic              pause_rise, left_rise, right_rise;
    logic [MIX_W-1:0]  mix_sum;

    assign pause_rise = pause & ~pause_q;
    assign left_rise  = left & ~left_q;
    assign right_rise = right & ~right_q;

    // Voice v claims the v-th lowest set key; extra keys are dropped.
    always_comb begin
        int n;
        n       = 0;
        sel_act = '0;
        for (int v = 0; v < VOICES; v++) begin
            sel_key[v] = 4'd0;
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keys[k]) begin
                for (int v = 0; v < VOICES; v++) begin
                    if (n == v) begin
                        sel_act[v] = 1'b1;
                        sel_key[v] = 4'(k);
                    end
                end
                n = n + 1;
            end
        end
    end

    // Control path: edge registers, enable toggle, band update.
    always_comb begin
        pause_d = pause;
        left_d  = left;
        right_d = right;
        en_d    = en_q ^ pause_rise;
        band_d  = band_q;
        if (adj) begin
            band_d = (bandi > BAND_TOP) ? BAND_TOP : bandi;
        end else if (left_rise && !right_rise) begin
`ifdef TONE_SYNTH_BAND_WRAP_EN
            band_d = band_q - 3'd1;
`else
            if (band_q != 3'd0) begin
                band_d = band_q - 3'd1;
            end
`endif
        end else if (right_rise && !left_rise) begin
`ifdef TONE_SYNTH_BAND_WRAP_EN
            band_d = band_q + 3'd1;
`else
            if (band_q < BAND_TOP) begin
                band_d = band_q + 3'd1;
            end
`endif
        end
    end

    // Voices: a new assignment restarts the phase; otherwise count
    // and relatch the half-period only at a boundary.
    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            cnt_d[v]    = cnt_q[v];
            hp_d[v]     = hp_q[v];
            key_d[v]    = key_q[v];
            active_d[v] = active_q[v];
            wave_d[v]   = wave_q[v];
            if (!sel_act[v]) begin
                cnt_d[v]    = 32'd0;
                wave_d[v]   = 1'b0;
                active_d[v] = 1'b0;
            end else if (!active_q[v] || sel_key[v] != key_q[v]) begin
                cnt_d[v]    = 32'd0;
                wave_d[v]   = 1'b0;
                active_d[v] = 1'b1;
                key_d[v]    = sel_key[v];
                hp_d[v]     = hp_of(sel_key[v], band_q);
            end else if (en_q) begin
                if (cnt_q[v] == hp_q[v] - 32'd1) begin
                    cnt_d[v]  = 32'd0;
                    wave_d[v] = ~wave_q[v];
                    hp_d[v]   = hp_of(key_q[v], band_q);
                end else begin
                    cnt_d[v] = cnt_q[v] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            band_q   <= 3'd2;
            pause_q  <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            active_q <= '0;
            wave_q   <= '0;
            for (int v = 0; v < VOICES; v++) begin
                cnt_q[v] <= 32'd0;
                hp_q[v]  <= 32'd0;
                key_q[v] <= 4'd0;
            end
        end else begin
            en_q     <= en_d;
            band_q   <= band_d;
            pause_q  <= pause_d;
            left_q   <= left_d;
            right_q  <= right_d;
            active_q <= active_d;
            wave_q   <= wave_d;
            for (int v = 0; v < VOICES; v++) begin
                cnt_q[v] <= cnt_d[v];
                hp_q[v]  <= hp_d[v];
                key_q[v] <= key_d[v];
            end
        end
    end

    // Mix is taken straight from the registers so it tracks wave.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (wave_q[v] && active_q[v]) begin
                mix_sum = mix_sum + MIX_W'(1);
            end
        end
    end

    assign en     = en_q;
    assign band   = band_q;
    assign wave   = wave_q;
    assign active = active_q;
    assign mix    = en_q ? mix_sum : '0;
    assign bell   = en_q && (|(wave_q & active_q));

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: self-checking bench for tone_synth with an
// event-level reference model, directed timing checks and random traffic.
module tb_tone_synth;

    localparam int CLK  = 1_000_000;
    localparam int NK   = 16;
    localparam int NV   = 2;
    localparam int BMAX = 7;

    logic          clk;
    logic          rst;
    logic [NK-1:0] keys;
    logic          pause, left, right, adj;
    logic [2:0]    bandi;
    logic          en;
    logic [2:0]    band;
    logic [NV-1:0] wave, active;
    logic [1:0]    mix;
    logic          bell;

    tone_synth #(
        .CLK_HZ(CLK), .NUM_KEYS(NK), .VOICES(NV), .BAND_MAX(BMAX)
    ) dut (
        .clk(clk), .rst(rst), .keys(keys), .pause(pause),
        .left(left), .right(right), .adj(adj), .bandi(bandi),
        .en(en), .band(band), .wave(wave), .active(active),
        .mix(mix), .bell(bell)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit cmp_on = 1'b0;

    int ftab [16] = '{1865, 1976, 2093, 2217, 2349, 2489, 2637, 2794,
                      2960, 3136, 3322, 3520, 3729, 3951, 4186, 4434};

    // Reference model: per-voice key, half-period, cycles to next toggle.
    int m_en = 0;
    int m_band = 2;
    bit pp = 0, pl = 0, pr = 0;
    int mkey [NV];
    int mhp [NV];
    int mleft [NV];
    bit mw [NV];

    int t0q [$];
    int t1q [$];

    function automatic int hp_ref(input int k, input int b);
        int h;
        h = (CLK / (2 * ftab[k])) * (1 << b);
        if (h < 2) h = 2;
        return h;
    endfunction

    task automatic model_step();
        int list [$];
        int nk;
        bit lr, rr, prr;
        if (rst) begin
            m_en = 0; m_band = 2; pp = 0; pl = 0; pr = 0;
            for (int v = 0; v < NV; v++) begin
                mkey[v] = -1; mw[v] = 0; mhp[v] = 0; mleft[v] = 0;
            end
            return;
        end
        for (int k = 0; k < NK; k++) if (keys[k]) list.push_back(k);
        for (int v = 0; v < NV; v++) begin
            nk = (v < list.size()) ? list[v] : -1;
            if (nk < 0) begin
                mkey[v] = -1; mw[v] = 0;
            end else if (nk != mkey[v]) begin
                mkey[v] = nk; mw[v] = 0;
                mhp[v] = hp_ref(nk, m_band); mleft[v] = mhp[v];
            end else if (m_en != 0) begin
                mleft[v]--;
                if (mleft[v] == 0) begin
                    mw[v] = ~mw[v];
                    mhp[v] = hp_ref(mkey[v], m_band);
                    mleft[v] = mhp[v];
                end
            end
        end
        prr = pause && !pp;
        lr  = left && !pl;
        rr  = right && !pr;
        pp = pause; pl = left; pr = right;
        if (prr) m_en = 1 - m_en;
        if (adj) begin
            m_band = (bandi > BMAX) ? BMAX : bandi;
        end else if (lr && !rr) begin
`ifdef TONE_SYNTH_BAND_WRAP_EN
            m_band = (m_band + 7) % 8;
`else
            m_band = (m_band > 0) ? m_band - 1 : 0;
`endif
        end else if (rr && !lr) begin
`ifdef TONE_SYNTH_BAND_WRAP_EN
            m_band = (m_band + 1) % 8;
`else
            m_band = (m_band < BMAX) ? m_band + 1 : BMAX;
`endif
        end
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            mkey[v] = -1; mw[v] = 0; mhp[v] = 0; mleft[v] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                         nm, a, e, cyc);
        end
    endtask

    // Every-cycle comparison against the model, plus toggle timestamps.
    logic pw0 = 1'b0, pw1 = 1'b0;
    initial begin
        forever begin
            int n;
            logic [NV-1:0] ea, ew;
            @(negedge clk);
            if (cmp_on) begin
                n = 0; ea = '0; ew = '0;
                for (int v = 0; v < NV; v++) begin
                    ea[v] = (mkey[v] >= 0);
                    ew[v] = mw[v];
                    if (ea[v] && ew[v]) n++;
                end
                chk("en", int'(en), m_en);
                chk("band", int'(band), m_band);
                chk("active", int'(active), int'(ea));
                chk("wave", int'(wave), int'(ew));
                chk("mix", int'(mix), (m_en != 0) ? n : 0);
                chk("bell", int'(bell), (m_en != 0 && n > 0) ? 1 : 0);
            end
            if (wave[0] !== pw0) t0q.push_back(cyc);
            if (wave[1] !== pw1) t1q.push_back(cyc);
            pw0 = wave[0];
            pw1 = wave[1];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_q(input int which, input int n, input int bound,
                          input string nm);
        for (int i = 0; i < bound; i++) begin
            if ((which == 0 ? t0q.size() : t1q.size()) >= n) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL %s: timeout after %0d cycles, need %0d toggles",
                 nm, bound, n);
    endtask

    task automatic pulse_left();
        left = 1'b1; tick(); left = 1'b0; tick();
    endtask

    initial begin
        int tset, n0, r;
        logic [NV-1:0] w;
        bit seen [3];
        bit got;
        rst = 1'b1; keys = '0; pause = 1'b0; left = 1'b0;
        right = 1'b0; adj = 1'b0; bandi = 3'd0;
        repeat (3) tick();
        cmp_on = 1'b1;
        chk("rst_en", int'(en), 0);
        chk("rst_band", int'(band), 2);
        chk("rst_active", int'(active), 0);
        chk("rst_mix", int'(mix), 0);
        chk("rst_bell", int'(bell), 0);
        rst = 1'b0;
        tick();

        // Enable, single key at band 2.
        pause = 1'b1; tick(); pause = 1'b0;
        chk("en_on", int'(en), 1);
        tick();
        keys = 16'h0001; tset = cyc;
        t0q.delete();
        wait_q(0, 2, 3000, "key0_b2");
        if (t0q.size() >= 2) begin
            chk("first_toggle", t0q[0] - tset, 1073);
            chk("half_period_b2", t0q[1] - t0q[0], 1072);
        end

        // Band stepping and saturation / wrap.
        pulse_left();
        pulse_left();
        chk("band_zero", int'(band), 0);
        pulse_left();
`ifdef TONE_SYNTH_BAND_WRAP_EN
        chk("band_low_edge", int'(band), 7);
`else
        chk("band_low_edge", int'(band), 0);
`endif
        pulse_left();
        pulse_left();
        adj = 1'b1; bandi = 3'd0; tick(); adj = 1'b0; tick();
        chk("band_adj0", int'(band), 0);
        left = 1'b1; right = 1'b1; tick();
        left = 1'b0; right = 1'b0; tick();
        chk("band_cancel", int'(band), 0);
        right = 1'b1; repeat (5) tick(); right = 1'b0; tick();
        chk("band_hold_once", int'(band), 1);
        adj = 1'b1; bandi = 3'd0; right = 1'b1; tick();
        adj = 1'b0; right = 1'b0; tick();
        chk("adj_prio", int'(band), 0);

        // Two voices at band 0, key14 ignored.
        keys = '0; tick();
        keys = 16'h4005;
        t0q.delete(); t1q.delete();
        tick();
        chk("active_two", int'(active), 3);
        seen[0] = 0; seen[1] = 0; seen[2] = 0;
        for (int i = 0; i < 3000; i++) begin
            if (t0q.size() >= 3 && t1q.size() >= 3) break;
            seen[mix] = 1'b1;
            tick();
        end
        wait_q(0, 3, 10, "two_v0");
        wait_q(1, 3, 10, "two_v1");
        if (t0q.size() >= 3) chk("hp_key0_b0", t0q[2] - t0q[1], 268);
        if (t1q.size() >= 3) chk("hp_key2_b0", t1q[2] - t1q[1], 238);
        chk("mix_seen0", int'(seen[0]), 1);
        chk("mix_seen1", int'(seen[1]), 1);
        chk("mix_seen2", int'(seen[2]), 1);

        // Pause while sounding.
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bell) begin got = 1'b1; break; end
            tick();
        end
        chk("bell_sounding", int'(got), 1);
        pause = 1'b1; tick(); pause = 1'b0;
        chk("pause_bell", int'(bell), 0);
        chk("pause_mix", int'(mix), 0);
        w = wave; n0 = t0q.size() + t1q.size();
        repeat (300) tick();
        chk("pause_freeze", int'(wave), int'(w));
        chk("pause_no_toggle", t0q.size() + t1q.size(), n0);
        pause = 1'b1; tick(); pause = 1'b0;
        chk("resume_en", int'(en), 1);
        repeat (600) tick();

        // Band change mid-half-period.
        keys = '0; tick();
        keys = 16'h0001; tick();
        t0q.delete();
        wait_q(0, 1, 600, "midband_a");
        repeat (100) tick();
        right = 1'b1; tick(); right = 1'b0;
        wait_q(0, 3, 2000, "midband_b");
        if (t0q.size() >= 3) begin
            chk("midband_cur", t0q[1] - t0q[0], 268);
            chk("midband_next", t0q[2] - t0q[1], 536);
        end

        // Reset mid-tone.
        keys = 16'h4005;
        repeat (300) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_en", int'(en), 0);
        chk("mid_rst_band", int'(band), 2);
        chk("mid_rst_active", int'(active), 0);
        chk("mid_rst_wave", int'(wave), 0);
        chk("mid_rst_mix", int'(mix), 0);
        chk("mid_rst_bell", int'(bell), 0);
        repeat (200) tick();
        chk("post_rst_quiet", int'(bell), 0);

        // Random traffic against the model.
        pause = 1'b1; tick(); pause = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) keys = 16'($urandom);
            else if (r < 6) keys = 16'(1 << $urandom_range(0, 15));
            else if (r < 8) keys = '0;
            if ($urandom_range(0, 399) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) left = ~left;
            if ($urandom_range(0, 49) == 0) right = ~right;
            adj = ($urandom_range(0, 199) == 0);
            bandi = 3'($urandom_range(0, 7));
            if (bandi > 3'd2 && $urandom_range(0, 3) != 0) bandi = 3'd1;
            rst = ($urandom_range(0, 4999) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_synth.md
# tone_synth

Polyphonic square-wave tone generator, the parametrised successor of the single-voice switch-to-pitch music box. Maps up to 16 key inputs onto `VOICES` independent tone voices using a fixed 16-entry pitch table and a shared octave band. Provides per-voice waves, a summed mix level and a 1-bit bell output for the board speaker/PWM stage. Pause, octave-step and octave-load controls are edge-detected internally.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000: clock frequency; pitch half-periods derive from it.
- `NUM_KEYS`, 16: key inputs, 1..16; key k uses table entry k.
- `VOICES`, 2: simultaneous voices, 1..4.
- `BAND_MAX`, 7: highest octave band; `band` is 3 bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `keys`  in  NUM_KEYS  level key switches.
- `pause`  in  1  level; a rising edge toggles `en`.
- `left`  in  1  level; a rising edge decrements `band` (raises pitch).
- `right`  in  1  level; a rising edge increments `band` (lowers pitch).
- `adj`  in  1  level; while high, `band` loads `bandi` every cycle.
- `bandi`  in  3  band load value; values above BAND_MAX clamp to BAND_MAX.
- `en`  out  1  playback enable.
- `band`  out  3  current octave band.
- `wave`  out  VOICES  per-voice square waves.
- `active`  out  VOICES  voice has an assigned key.
- `mix`  out  clog2(VOICES+1)  popcount of `wave & active`, 0 while `en`=0.
- `bell`  out  1  OR of `wave & active`, 0 while `en`=0.

## Operation

- Pitch table in Hz, index 0..15: 1865 1976 2093 2217 2349 2489 2637 2794 2960 3136 3322 3520 3729 3951 4186 4434.
- Half-period: HP(k,b) = (CLK_HZ / (2*F[k])) << b. Integer division truncates. Counters are 32 bits wide; HP=0 or 1 is clamped to 2.
- Allocation: voice v takes the v-th lowest-index set bit of `keys`. Any keys beyond VOICES are ignored, and surplus voices are inactive.
- Key change: when a voice's assigned key changes (including idle to active), its counter and `wave[v]` clear to 0 and HP is latched for the new key.
- Counting: while `en`=1 and the voice is active, cnt increments. When cnt == HP_latched-1, cnt returns to 0, `wave[v]` toggles and HP is relatched from the current `band`. Band changes therefore take effect only at half-period boundaries, so no glitch occurs.
- While `en`=0, counters and waves hold their values, and `mix` and `bell` are forced to 0.
- An inactive voice has cnt=0 and `wave`=0.
- Band priority per cycle is `adj` > step. Rising edges of `left` and `right` in the same cycle cancel. The band saturates at 0 and BAND_MAX (see Configuration).
- `pause`, `left` and `right` each pass through a one-register edge detector. A level held high acts exactly once.
- Reset values: `en`=0, `band`=2, `wave`=0, `active`=0, `mix`=0, `bell`=0, all counters 0, edge registers 0.

## Timing

- `keys` sampled at edge t produce `active` and the voice assignment at t+1, with cnt=0.
- The first toggle occurs at edge t+1+HP. The steady-state period is 2*HP cycles.
- Control rising edge at input cycle t: `en` or `band` update at t+1.
- `mix` and `bell` are registered and lag `wave` by 0 cycles, because they are computed from the same-cycle register values.
- `rst` asserted mid-tone: all state returns to reset values on the next edge. After deassertion, `en`=0, so there is no output until a pause edge.
- Key released mid-half-period: `active` falls and `wave` becomes 0 at the next edge.

## Configuration

- `TONE_SYNTH_BAND_WRAP_EN` defined: band stepping wraps modulo 8 (0→7 on left, 7→0 on right), preserving the legacy music-box behaviour. In this mode BAND_MAX must equal 7.
- Not defined (default): band stepping saturates at 0 and BAND_MAX.

## Test plan

- CLK_HZ=1_000_000, VOICES=2. After reset, pulse `pause`, then set `keys`=0x0001. Required: `en`=1, `band`=2, HP=268<<2=1072, and `wave[0]` toggles every 1072 cycles.
- `keys`=0x4005 at band 0. Required: voice0 uses key0 (HP 268), voice1 uses key2 (HP 238), key14 is ignored, `active`=2'b11, and `mix` takes values 0/1/2.
- Step `band` to 0, then apply 3 further `left` edges. Required: `band` stays 0, and with the WRAP macro it reads 7 after the first extra edge. Simultaneous `left` and `right` edges leave `band` unchanged.
- While a key is sounding, pulse `pause`. Required: `bell` and `mix` are 0 the next cycle and cnt freezes. Pulsing `pause` again resumes from the same cnt.
- Change `band` from 0 to 1 mid-half-period on key0. Required: the current half-period completes at 268 cycles and the next one is 536.
- Assert `rst` for 1 cycle while 2 voices play. Required: all outputs are at reset values at the next edge, and `band`=2.
